// File: rtl/shift_right_pipe_pkg.sv
// Shared constants and helpers for the pipelined right shifter.
package fp_shift_pkg;

    // Guard, round and sticky bits delivered with every result.
    localparam int GRS_W  = 3;

    // Widest shifter datapath (WIDTH+2) the sticky helper supports.
    localparam int MAX_DW = 128;

    // OR of the bits a right shift by amt discards from the bottom of d.
    // Callers zero-extend their datapath into d, so bits above their own
    // width never contribute. An amount at or beyond the width discards
    // everything.
    function automatic logic discard_or(input logic [MAX_DW-1:0] d, input int amt);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < MAX_DW; i++) begin
            if (i < amt) begin
                acc = acc | d[i];
            end else begin
                acc = acc;
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/shift_right_pipe_if.sv
// Valid/ready bus of the shifter: request side (value, amount, fill mode,
// tag) and result side (shifted value, guard/round/sticky, tag).
interface shift_right_pipe_if #(
    parameter int WIDTH = 24,
    parameter int SHW   = 5,
    parameter int TAGW  = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in;
    logic [SHW-1:0]   shift;
    logic             arith;
    logic [TAGW-1:0]  in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             guard;
    logic             round;
    logic             sticky;
    logic [TAGW-1:0]  out_tag;

    modport master (
        output in_valid, in, shift, arith, in_tag, out_ready,
        input  in_ready, out_valid, out, guard, round, sticky, out_tag
    );

    modport slave (
        input  in_valid, in, shift, arith, in_tag, out_ready,
        output in_ready, out_valid, out, guard, round, sticky, out_tag
    );
endinterface

// File: rtl/shift_right_pipe_level.sv
// One shift level: conditionally shifts right by AMT with fill, folds the
// discarded bits into the running sticky, and registers the stage record.
module shift_right_level
    import fp_shift_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int SHW   = 5,
    parameter int TAGW  = 4,
    parameter int LEVEL = 0,
    parameter int AMT   = 1 << LEVEL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             src_valid,
    input  logic [WIDTH+1:0] src_data,
    input  logic             src_sticky,
    input  logic [SHW-1:0]   src_shamt,
    input  logic             src_fill,
    input  logic [TAGW-1:0]  src_tag,
    output logic             dst_valid,
    output logic [WIDTH+1:0] dst_data,
    output logic             dst_sticky,
    output logic [SHW-1:0]   dst_shamt,
    output logic             dst_fill,
    output logic [TAGW-1:0]  dst_tag
);
    localparam int DW = WIDTH + 2;

    typedef struct packed {
        logic            valid;
        logic [DW-1:0]   data;
        logic            sticky;
        logic [SHW-1:0]  shamt;
        logic            fill;
        logic [TAGW-1:0] tag;
    } stage_t;

    logic [DW-1:0] shifted_s;
    stage_t        nxt_s;
    stage_t        stage_r;

    // Fixed shift by AMT: bits that fall off the top of the source are
    // replaced by the fill bit; AMT >= DW yields pure fill.
    for (genvar i = 0; i < DW; i++) begin : g_bit
        if (i + AMT < DW) begin : g_take
            assign shifted_s[i] = src_data[i + AMT];
        end else begin : g_fill
            assign shifted_s[i] = src_fill;
        end
    end

    // Build the next stage record, shifting only when this level's bit is set.
    always_comb begin
        nxt_s        = '0;
        nxt_s.valid  = src_valid;
        nxt_s.shamt  = src_shamt;
        nxt_s.fill   = src_fill;
        nxt_s.tag    = src_tag;
        nxt_s.data   = src_data;
        nxt_s.sticky = src_sticky;
        if (src_shamt[LEVEL]) begin
            nxt_s.data   = shifted_s;
            nxt_s.sticky = src_sticky | discard_or(MAX_DW'(src_data), AMT);
        end else begin
            nxt_s.data   = src_data;
            nxt_s.sticky = src_sticky;
        end
    end

    // Stage register: cleared on reset, loaded on global advance, else held (bubbles included).
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_r <= '0;
        end else if (en) begin
            stage_r <= nxt_s;
        end else begin
            stage_r <= stage_r;
        end
    end

    assign dst_valid  = stage_r.valid;
    assign dst_data   = stage_r.data;
    assign dst_sticky = stage_r.sticky;
    assign dst_shamt  = stage_r.shamt;
    assign dst_fill   = stage_r.fill;
    assign dst_tag    = stage_r.tag;

endmodule

// File: rtl/shift_right_pipe.sv
// Pipelined right barrel shifter with guard/round/sticky for FP alignment
// and normalisation. Level SHW-1 (largest step) is first, level 0 last; one
// register per level, so the result appears SHW cycles after acceptance.
module shift_right_pipe
    import fp_shift_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int SHW   = 5,
    parameter int TAGW  = 4
) (
    input logic               clk,
    input logic               rst,
    shift_right_pipe_if.slave bus
);
    // Datapath carries the value plus guard and round positions below it.
    localparam int DW = WIDTH + GRS_W - 1;

    logic            en_s;
    logic            st_valid_s  [0:SHW];
    logic [DW-1:0]   st_data_s   [0:SHW];
    logic            st_sticky_s [0:SHW];
    logic [SHW-1:0]  st_shamt_s  [0:SHW];
    logic            st_fill_s   [0:SHW];
    logic [TAGW-1:0] st_tag_s    [0:SHW];
    logic            unused_tail_s;

    // The whole pipe advances together; a stalled head freezes every stage.
    assign en_s         = !st_valid_s[SHW] || bus.out_ready;
    assign bus.in_ready = en_s;

    // Entry record: value placed above two zero guard/round bits.
    assign st_valid_s[0]  = bus.in_valid;
    assign st_data_s[0]   = {bus.in, {(GRS_W-1){1'b0}}};
    assign st_sticky_s[0] = 1'b0;
    assign st_shamt_s[0]  = bus.shift;
    assign st_fill_s[0]   = bus.arith & bus.in[WIDTH-1];
    assign st_tag_s[0]    = bus.in_tag;

    for (genvar j = 0; j < SHW; j++) begin : g_lvl
        shift_right_level #(
            .WIDTH (WIDTH),
            .SHW   (SHW),
            .TAGW  (TAGW),
            .LEVEL (SHW - 1 - j)
        ) u_level (
            .clk        (clk),
            .rst        (rst),
            .en         (en_s),
            .src_valid  (st_valid_s[j]),
            .src_data   (st_data_s[j]),
            .src_sticky (st_sticky_s[j]),
            .src_shamt  (st_shamt_s[j]),
            .src_fill   (st_fill_s[j]),
            .src_tag    (st_tag_s[j]),
            .dst_valid  (st_valid_s[j+1]),
            .dst_data   (st_data_s[j+1]),
            .dst_sticky (st_sticky_s[j+1]),
            .dst_shamt  (st_shamt_s[j+1]),
            .dst_fill   (st_fill_s[j+1]),
            .dst_tag    (st_tag_s[j+1])
        );
    end

    // Results come straight from the final stage register.
    assign bus.out_valid = st_valid_s[SHW];
    assign bus.out       = st_data_s[SHW][DW-1:GRS_W-1];
    assign bus.guard     = st_data_s[SHW][1];
    assign bus.round     = st_data_s[SHW][0];
    assign bus.sticky    = st_sticky_s[SHW];
    assign bus.out_tag   = st_tag_s[SHW];

    // Shift amount and fill are no longer needed once the last level is done.
    assign unused_tail_s = ^{st_shamt_s[SHW], st_fill_s[SHW]};

endmodule

// File: tb/tb_shift_right_pipe.sv
// Scoreboard bench for shift_right_pipe: the driver pushes hand-computed
// expectations on acceptance, a negedge monitor pops and compares on each
// output handshake.
module tb_shift_right_pipe;
    localparam int WIDTH = 24;
    localparam int SHW   = 5;
    localparam int TAGW  = 4;

    typedef struct packed {
        logic [23:0] data;
        logic        g;
        logic        r;
        logic        s;
        logic [3:0]  tag;
    } exp_t;

    typedef struct packed {
        logic [23:0] vin;
        logic [4:0]  sh;
        logic        ar;
        logic [23:0] vout;
        logic        g;
        logic        r;
        logic        s;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    exp_t sb_q[$];
    vec_t vecs[12];

    always #5 clk = ~clk;

    shift_right_pipe_if #(.WIDTH(WIDTH), .SHW(SHW), .TAGW(TAGW)) bus ();

    shift_right_pipe #(.WIDTH(WIDTH), .SHW(SHW), .TAGW(TAGW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every output handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_result", 32'(bus.out_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("out",     32'(bus.out),     32'(e.data));
                check("guard",   32'(bus.guard),   32'(e.g));
                check("round",   32'(bus.round),   32'(e.r));
                check("sticky",  32'(bus.sticky),  32'(e.s));
                check("out_tag", 32'(bus.out_tag), 32'(e.tag));
            end
        end
    end

    task automatic send(input int idx, input logic [3:0] tag, input bit push);
        bit   done;
        exp_t e;
        done         = 1'b0;
        bus.in_valid = 1'b1;
        bus.in       = vecs[idx].vin;
        bus.shift    = vecs[idx].sh;
        bus.arith    = vecs[idx].ar;
        bus.in_tag   = tag;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                done = 1'b1;
                if (push) begin
                    e.data = vecs[idx].vout;
                    e.g    = vecs[idx].g;
                    e.r    = vecs[idx].r;
                    e.s    = vecs[idx].s;
                    e.tag  = tag;
                    sb_q.push_back(e);
                end
            end
            @(posedge clk);
            #1;
        end
        check("send_accepted", 32'(done), 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 100 && sb_q.size() != 0; c++) begin
            @(posedge clk);
        end
        #1;
        check("drain_empty", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [30:0] snap;
        bit          seen;

        // in, shift, arith, out, guard, round, sticky
        vecs[0]  = '{24'h800001, 5'd1,  1'b0, 24'h400000, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{24'h800003, 5'd3,  1'b0, 24'h100000, 1'b0, 1'b1, 1'b1};
        vecs[2]  = '{24'h800000, 5'd31, 1'b1, 24'hFFFFFF, 1'b1, 1'b1, 1'b1};
        vecs[3]  = '{24'h800000, 5'd31, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{24'hABCDEF, 5'd0,  1'b0, 24'hABCDEF, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{24'h800000, 5'd4,  1'b1, 24'hF80000, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{24'h000001, 5'd26, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{24'h800000, 5'd25, 1'b0, 24'h000000, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{24'hC00000, 5'd24, 1'b0, 24'h000000, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{24'h000003, 5'd2,  1'b0, 24'h000000, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{24'h7FFFFF, 5'd5,  1'b1, 24'h03FFFF, 1'b1, 1'b1, 1'b1};
        vecs[11] = '{24'h8000C0, 5'd7,  1'b1, 24'hFF0001, 1'b1, 1'b0, 1'b0};

        bus.in_valid  = 1'b0;
        bus.in        = '0;
        bus.shift     = '0;
        bus.arith     = 1'b0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;

        // Reset state.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out",       32'(bus.out),       32'd0);
        check("rst_grs",       32'({bus.guard, bus.round, bus.sticky}), 32'd0);
        check("rst_out_tag",   32'(bus.out_tag),   32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        rst = 1'b0;

        // Directed vectors, back to back.
        for (int i = 0; i < 12; i++) begin
            send(i, 4'(i + 1), 1'b1);
        end
        drain();

        // Latency on an empty pipe: visible in cycle SHW after the accept edge.
        send(4, 4'h5, 1'b1);
        for (int k = 1; k <= SHW; k++) begin
            if (k > 1) begin
                @(posedge clk);
                #1;
            end
            check("latency_out_valid", 32'(bus.out_valid), 32'(k == SHW));
        end
        drain();

        // Stream of 8 with a 4-cycle stall as soon as the first result shows.
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(i, 4'(8 + i), 1'b1);
                end
            end
            begin
                seen = 1'b0;
                for (int c = 0; c < 60 && !seen; c++) begin
                    @(posedge clk);
                    #1;
                    if (bus.out_valid) begin
                        seen = 1'b1;
                    end
                end
                check("stall_saw_valid", 32'(seen), 32'd1);
                bus.out_ready = 1'b0;
                snap = {bus.out, bus.guard, bus.round, bus.sticky, bus.out_tag};
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk);
                    check("stall_in_ready",  32'(bus.in_ready),  32'd0);
                    check("stall_out_valid", 32'(bus.out_valid), 32'd1);
                    check("stall_stable",
                          32'({bus.out, bus.guard, bus.round, bus.sticky, bus.out_tag}),
                          32'(snap));
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three transactions in flight: none may ever emerge.
        for (int i = 0; i < 3; i++) begin
            send(i, 4'(13 + i), 1'b0);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_out",       32'(bus.out),       32'd0);
        check("midrst_grs",       32'({bus.guard, bus.round, bus.sticky}), 32'd0);
        check("midrst_out_tag",   32'(bus.out_tag),   32'd0);
        rst = 1'b0;
        check("midrst_in_ready",  32'(bus.in_ready),  32'd1);
        repeat (12) @(posedge clk);
        #1;

        // Pipe still works after the flush.
        send(1, 4'h6, 1'b1);
        drain();

        check("final_queue_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_right_pipe.md
Name: shift_right_pipe

Overview:
- Parametrised, pipelined right barrel shifter for the FP datapath (mantissa alignment in add/sub, post-normalise in MUL).
- Generalises the fixed 24-bit combinational 16/8/4/2/1 shifter:
  - WIDTH and shift-amount width are parameters.
  - One register stage per shift level.
  - Valid/ready handshake with backpressure.
  - Logical or arithmetic fill.
  - Guard, round and sticky outputs for IEEE-754 rounding.

Parameters:
- WIDTH, 24: data width (mantissa incl. hidden bit); legal range ≥ 4.
- SHW, 5: shift-amount width; number of shift levels = pipeline depth.
- TAGW, 4: width of opaque sideband tag carried alongside the data.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input transaction present.
- in_ready  out  1  block accepts the input this cycle.
- in  in  WIDTH  value to shift.
- shift  in  SHW  right-shift amount, 0..2^SHW-1.
- arith  in  1  1 = fill with in[WIDTH-1]; 0 = fill with zeros.
- in_tag  in  TAGW  sideband tag, passed through unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- out  out  WIDTH  shifted value.
- guard  out  1  first bit below out LSB.
- round  out  1  second bit below out LSB.
- sticky  out  1  OR of every bit shifted below round.
- out_tag  out  TAGW  tag of this result.

Behaviour:
- Arithmetic definition:
  - E = {in, 2'b00}, WIDTH+2 bits.
  - R = E shifted right by shift, filled with (arith ? in[WIDTH-1] : 0).
  - out = R[WIDTH+1:2]; guard = R[1]; round = R[0].
  - sticky = OR of the bits of E shifted out past bit 0.
- Large shifts: shift ≥ WIDTH+2 is legal.
  - out/guard/round = all fill.
  - sticky = |in[WIDTH-1:0] (E's bits 1:0 are zero).
- No top-bit override: the MSB of out is always the fill/shifted value, never forced from in.
- Pipeline structure:
  - SHW levels. Level k (k = SHW-1 downto 0) shifts by 2^k when shift[k] = 1, ORs the bits it discards into a running sticky, then registers.
  - Each stage holds: data (WIDTH+2), sticky, remaining shift bits, arith/fill bit, tag, valid.
  - Level shifting by ≥ WIDTH+2: discards everything; result is full fill plus OR of the stage contents.
- Latency and throughput:
  - Latency exactly SHW cycles from accept (in_valid && in_ready) to out_valid.
  - Throughput 1 per cycle.
- Flow control:
  - Global advance enable en = !out_valid || out_ready.
  - in_ready = en (combinational from out_valid/out_ready only, never from in_valid).
  - When en = 0, every stage register holds, including bubbles.
  - When en = 1, each stage loads its predecessor; stage 0 loads valid = in_valid.
- Handshake rules:
  - out/guard/round/sticky/out_tag are stable while out_valid && !out_ready.
  - in_valid may drop without handshake; an input not accepted is not captured.
  - Results leave in acceptance order; no reordering or dropping.
- Simultaneous events: final-stage pop and new accept in the same cycle are allowed (full throughput under out_ready = 1).
- Reset:
  - All valid bits clear; out_valid = 0.
  - out, guard, round, sticky, out_tag = 0.
  - Reset mid-operation discards all in-flight transactions; in_ready = 1 in the cycle after reset deasserts.
- Widths: no internal width growth beyond WIDTH+2; shift is unsigned.

Decomposition:
- Package fp_shift_pkg:
  - GRS_W = 3 constant.
  - Stage-record typedef {valid, data[WIDTH+2], sticky, shamt, fill, tag}.
  - Helper function for level shift-with-sticky.
- One natural sub-module: shift_right_level, parameters WIDTH and AMT.
  - Combinational shift of one level with fill and sticky-out, plus its pipeline register with enable.
  - Top instantiates SHW of them via generate.

Test Plan:
- WIDTH=24, SHW=5, out_ready=1: in=0x800001, shift=1, arith=0 → after 5 cycles out=0x400000, guard=1, round=0, sticky=0.
- in=0x800003, shift=3, arith=0 → out=0x100000, guard=0, round=1, sticky=1.
- in=0x800000, shift=31, arith=1 → out=0xFFFFFF, guard=1, round=1, sticky=1; same with arith=0 → out=0x000000, guard=0, round=0, sticky=1.
- shift=0, in=0xABCDEF, tag=0x5 → out=0xABCDEF, guard/round/sticky=0, out_tag=0x5, latency exactly 5 cycles.
- Stream 8 back-to-back inputs; hold out_ready=0 for 4 cycles once out_valid rises:
  - in_ready=0 and outputs stable while held.
  - After release, all 8 results arrive in order with correct tags and no duplicates.
- Fill pipeline with 3 transactions, assert rst for 1 cycle:
  - out_valid=0 and all outputs zero next cycle.
  - None of the 3 results ever appears; in_ready=1 after reset.
